load_store_unit: RTL and testbench

The load/store unit is the initiator side of the CPU's data memory port. It sits between the execute stage and the data memory and accepts one load or store per transaction from the pipeline. It converts RV32I byte, halfword and word accesses into word-aligned memory requests with byte enables, and waits for the memory handshake. Load results are aligned and sign- or zero-extended before they are returned to writeback.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/load_align.sv | 42 ++++
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the data-memory path of the CPU.
//               Holds the RV32I load/store width codes, the load/store unit
//               state encoding and the data-path geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int BYTE_SIZE = 8;
    localparam int MEM_STEPS = XLEN / BYTE_SIZE;

    // RV32I funct3 width/sign codes for loads and stores
    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load aligner. Moves the addressed byte/halfword
//               of a memory word down to bit 0 and sign- or zero-extends it.
// Ports       : mem_rdata_i  - raw word returned by memory
//               addr_lo_i    - byte offset within the word (addr[1:0])
//               funct3_i     - RV32I width/sign code
//               result_o     - extended XLEN load result (0 for illegal codes)
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] w_shifted;

    always_comb begin
        // byte offset times eight gives the bit shift
        w_shifted = mem_rdata_i >> {addr_lo_i, 3'b000};
        result_o  = '0;
        case (mem_width_e'(funct3_i))
            MW_B:    result_o = {{(XLEN-BYTE_SIZE){w_shifted[BYTE_SIZE-1]}},
                                 w_shifted[BYTE_SIZE-1:0]};
            MW_BU:   result_o = {{(XLEN-BYTE_SIZE){1'b0}},
                                 w_shifted[BYTE_SIZE-1:0]};
            MW_H:    result_o = {{(XLEN-2*BYTE_SIZE){w_shifted[2*BYTE_SIZE-1]}},
                                 w_shifted[2*BYTE_SIZE-1:0]};
            MW_HU:   result_o = {{(XLEN-2*BYTE_SIZE){1'b0}},
                                 w_shifted[2*BYTE_SIZE-1:0]};
            MW_W:    result_o = w_shifted;
            default: result_o = '0;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the data memory port. Accepts one RV32I
//               load/store from the pipeline, issues a word-aligned memory
//               request with byte enables, waits for mem_ready and returns a
//               one-cycle response with aligned/extended load data.
// Ports       : clk, rst              - clock, async active-high reset
//               req_*                 - pipeline request (valid/ready)
//               mem_*                 - data memory request/handshake
//               resp_*                - one-cycle writeback response
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [4:0]           req_rd,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [MEM_STEPS-1:0] mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_ready,
    input  logic [XLEN-1:0]      mem_rdata,

    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_data,
    output logic [4:0]           resp_rd,
    output logic                 resp_misaligned,
    output logic                 resp_illegal
);

    lsu_state_e           state_q;
    logic                 write_q;
    logic [2:0]           funct3_q;
    logic [1:0]           addr_lo_q;
    logic [4:0]           rd_q;

    logic                 req_ready_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [XLEN-1:0]      mem_addr_q;
    logic [MEM_STEPS-1:0] mem_be_q;
    logic [XLEN-1:0]      mem_wdata_q;
    logic                 resp_valid_q;
    logic [XLEN-1:0]      resp_data_q;
    logic [4:0]           resp_rd_q;
    logic                 resp_misaligned_q;
    logic                 resp_illegal_q;

    logic                 illegal_d;
    logic                 misaligned_d;
    logic [MEM_STEPS-1:0] be_d;
    logic [XLEN-1:0]      wdata_d;
    logic [XLEN-1:0]      load_data_d;

    // Decode of the incoming request: fault detection and store lanes
    always_comb begin
        illegal_d    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111);
        misaligned_d = 1'b0;
        be_d         = '0;
        wdata_d      = '0;
        case (req_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {MEM_STEPS{req_wdata[BYTE_SIZE-1:0]}};
            end
            2'b01: begin
                misaligned_d = req_addr[0];
                be_d         = 4'b0011 << req_addr[1:0];
                wdata_d      = {(MEM_STEPS/2){req_wdata[2*BYTE_SIZE-1:0]}};
            end
            2'b10: begin
                misaligned_d = (req_addr[1:0] != 2'b00);
                be_d         = '1;
                wdata_d      = req_wdata;
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .mem_rdata_i (mem_rdata),
        .addr_lo_i   (addr_lo_q),
        .funct3_i    (funct3_q),
        .result_o    (load_data_d)
    );

    // All outputs are registered; the async reset clears them directly, so
    // an abandoned ACCESS drops mem_req without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            write_q           <= 1'b0;
            funct3_q          <= 3'b000;
            addr_lo_q         <= 2'b00;
            rd_q              <= 5'd0;
            req_ready_q       <= 1'b1;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_be_q          <= '0;
            mem_wdata_q       <= '0;
            resp_valid_q      <= 1'b0;
            resp_data_q       <= '0;
            resp_rd_q         <= 5'd0;
            resp_misaligned_q <= 1'b0;
            resp_illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        funct3_q    <= req_funct3;
                        addr_lo_q   <= req_addr[1:0];
                        rd_q        <= req_rd;
                        req_ready_q <= 1'b0;
                        if (illegal_d || misaligned_d) begin
                            state_q           <= RESP;
                            resp_valid_q      <= 1'b1;
                            resp_data_q       <= '0;
                            resp_rd_q         <= req_rd;
                            // illegal wins over misaligned
                            resp_misaligned_q <= misaligned_d && !illegal_d;
                            resp_illegal_q    <= illegal_d;
                        end else begin
                            state_q     <= ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_write;
                            mem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_be_q    <= req_write ? be_d : '0;
                            mem_wdata_q <= req_write ? wdata_d : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_be_q     <= '0;
                        mem_wdata_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= write_q ? '0 : load_data_d;
                        resp_rd_q    <= rd_q;
                    end
                end
                RESP: begin
                    state_q           <= IDLE;
                    req_ready_q       <= 1'b1;
                    resp_valid_q      <= 1'b0;
                    resp_data_q       <= '0;
                    resp_rd_q         <= 5'd0;
                    resp_misaligned_q <= 1'b0;
                    resp_illegal_q    <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_be          = mem_be_q;
    assign mem_wdata       = mem_wdata_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_rd         = resp_rd_q;
    assign resp_misaligned = resp_misaligned_q;
    assign resp_illegal    = resp_illegal_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Directed cases from
//               the block's behaviour list plus randomized loads/stores, all
//               checked against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_misaligned;
    logic        resp_illegal;

    int n_vec  = 0;
    int n_fail = 0;

    load_store_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_rd         (resp_rd),
        .resp_misaligned (resp_misaligned),
        .resp_illegal    (resp_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_illegal(input logic [2:0] f3);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] a);
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] rdata);
        int          sz = acc_size(f3);
        logic [31:0] v  = 0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 1);
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input int off);
        logic [3:0] b = 0;
        for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + acc_size(f3));
        return b;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w  = 0;
        int          sz = acc_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
        return w;
    endfunction

    // One complete transaction: present request, serve memory after `dly`
    // cycles, check every observable output against the model.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int dly, input logic [31:0] rdata);
        bit fault = is_illegal(f3) || is_misal(f3, a);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        tick();
        req_valid = 1'b0;
        req_wdata = $urandom; req_addr = $urandom;
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        if (fault) begin
            chk("fault_no_memreq", {31'd0, mem_req}, 32'd0);
        end else begin
            for (int k = 1; k <= dly; k++) begin
                chk("mem_req", {31'd0, mem_req}, 32'd1);
                chk("mem_we", {31'd0, mem_we}, {31'd0, wr});
                chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("mem_be", {28'd0, mem_be}, wr ? {28'd0, ref_be(f3, a % 4)} : 32'd0);
                chk("mem_wdata", mem_wdata, wr ? ref_wdata(f3, wd) : 32'd0);
                chk("no_resp_in_access", {31'd0, resp_valid}, 32'd0);
                if (k == dly) begin
                    mem_ready = 1'b1; mem_rdata = rdata;
                end
                tick();
                mem_ready = 1'b0; mem_rdata = $urandom;
            end
            chk("mem_req_dropped", {31'd0, mem_req}, 32'd0);
        end
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, is_illegal(f3)});
        chk("resp_misaligned", {31'd0, resp_misaligned},
            {31'd0, !is_illegal(f3) && is_misal(f3, a)});
        chk("resp_data", resp_data, (fault || wr) ? 32'd0 : ref_load(f3, a % 4, rdata));
        chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
        // memory handshake in RESP must be ignored
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        chk("resp_data_cleared", resp_data, 32'd0);
        chk("idle_no_memreq", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 0; req_wdata = 0; req_rd = 0; mem_ready = 1'b0; mem_rdata = 0;
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // mem_ready while idle does nothing
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("idle_ready_ignored_req", {31'd0, mem_req}, 32'd0);
        chk("idle_ready_ignored_resp", {31'd0, resp_valid}, 32'd0);

        // Directed cases
        do_req(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd3, 3, 32'h0);
        do_req(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 5'd7, 1, 32'h0);
        do_req(1'b0, 3'b000, 32'h0000_0302, 32'h0, 5'd9, 2, 32'h1280_3456);
        chk("lb_literal", ref_load(3'b000, 2, 32'h1280_3456), 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h0000_0302, 32'h0, 5'd10, 1, 32'h1280_3456);
        do_req(1'b0, 3'b001, 32'h0000_0401, 32'h0, 5'd11, 1, 32'h0);
        do_req(1'b0, 3'b011, 32'h0000_0401, 32'h0, 5'd12, 1, 32'h0);
        do_req(1'b1, 3'b001, 32'h0000_0502, 32'h1234_BEEF, 5'd13, 2, 32'h0);
        do_req(1'b0, 3'b001, 32'h0000_0602, 32'h0, 5'd14, 1, 32'h8001_7FFF);
        do_req(1'b0, 3'b101, 32'h0000_0602, 32'h0, 5'd15, 1, 32'h8001_7FFF);

        // Reset in the middle of an access
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_0700; req_rd = 5'd20;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        do_req(1'b0, 3'b010, 32'h0000_0000, 32'h0, 5'd21, 2, 32'hCAFE_F00D);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic        wr = 1'($urandom);
            logic [31:0] a  = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rdv = $urandom;
            logic [4:0]  rd = 5'($urandom);
            int          dly = $urandom_range(1, 4);
            if ($urandom_range(0, 3) != 0) a = a & ~(acc_size(f3) - 1);
            do_req(wr, f3, a, wd, rd, dly, rdv);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire
